// File: rtl/dbg_hex_writer.sv
// dbg_hex_writer: snapshots a 256-bit debug bus and streams it as 64 ASCII hex chars into a character buffer
module dbg_hex_writer #(
  parameter bit UPPERCASE    = 1'b1,
  parameter bit AUTO_REFRESH = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] dbg_data,
  input  logic         print_fin,
  input  logic         refresh_req,
  input  logic         freeze,
  output logic         we,
  output logic [5:0]   wr_addr,
  output logic [7:0]   wr_data,
  output logic         busy,
  output logic         done,
  output logic         overrun
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [255:0] snap_q, snap_d;
  logic [5:0] idx_q, idx_d;
  logic pf_q;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic trig;
  logic [3:0] nib;
  logic [7:0] ascii;
  assign trig = refresh_req | (AUTO_REFRESH & print_fin & ~pf_q);
  // word idx[5:3], nibble idx[2:0] counted from the MSB end of the word
  assign nib = snap_q[{idx_q[5:3], ~idx_q[2:0], 2'b00} +: 4];
  assign ascii = ((nib < 4'd10) ? 8'h30 : (UPPERCASE ? 8'h37 : 8'h57)) + {4'h0, nib};
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    we_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    overrun_d = overrun_q | (trig & (state_q != IDLE));
    case (state_q)
      IDLE: if (trig && !freeze) begin
        state_d = WRITE;
        snap_d  = dbg_data;
        idx_d   = '0;
      end
      WRITE: begin
        we_d      = 1'b1;
        busy_d    = 1'b1;
        wr_addr_d = idx_q;
        wr_data_d = ascii;
        idx_d     = idx_q + 6'd1;
        state_d   = (idx_q == 6'd63) ? DONE : WRITE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      pf_q      <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h20;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      pf_q      <= print_fin;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign we      = we_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_dbg_hex_writer.sv
// tb_dbg_hex_writer: directed bench with a time-offset reference model and literal pins on captured characters
module tb_dbg_hex_writer;
  logic clk = 1'b0, rst = 1'b1;
  logic [255:0] dbg_data = '0;
  logic print_fin = 1'b0, refresh_req = 1'b0, freeze = 1'b0;
  logic we, busy, done, overrun;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic we_l, busy_l, done_l, overrun_l;
  logic [5:0] wr_addr_l;
  logic [7:0] wr_data_l;
  always #5 clk = ~clk;
  dbg_hex_writer dut (.clk(clk), .rst(rst), .dbg_data(dbg_data), .print_fin(print_fin),
    .refresh_req(refresh_req), .freeze(freeze), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overrun(overrun));
  dbg_hex_writer #(.UPPERCASE(1'b0)) dut_lc (.clk(clk), .rst(rst), .dbg_data(dbg_data), .print_fin(print_fin),
    .refresh_req(refresh_req), .freeze(freeze), .we(we_l), .wr_addr(wr_addr_l), .wr_data(wr_data_l),
    .busy(busy_l), .done(done_l), .overrun(overrun_l));
  int checks = 0, failures = 0, cyc = 0, wcount = 0, dcount = 0, done_cyc = 0;
  logic [7:0] mem [64];
  logic [7:0] mem_lc [64];
  logic [7:0] exp0 [8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44};
  logic [7:0] exp7 [8] = '{8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] hexc(int n, bit up);
    string s;
    s = up ? "0123456789ABCDEF" : "0123456789abcdef";
    return s.getc(n);
  endfunction
  // reference: k counts edges since a burst was accepted (-1 when idle)
  int k = -1;
  logic [255:0] m_snap;
  logic m_pf, m_over, e_we, e_busy, e_done;
  logic [5:0] e_addr;
  logic [7:0] e_data, e_data_l;
  bit m_on = 0;
  always @(posedge clk) begin
    bit t;
    int n;
    cyc++;
    if (rst) begin
      k = -1; m_pf = 0; m_over = 0; m_snap = '0;
      e_we = 0; e_busy = 0; e_done = 0; e_addr = 0; e_data = 8'h20; e_data_l = 8'h20;
      m_on = 1;
    end else begin
      t = refresh_req | (print_fin & !m_pf);
      m_pf = print_fin;
      e_we = 0; e_busy = 0; e_done = 0;
      if (k < 0) begin
        if (t && !freeze) begin k = 0; m_snap = dbg_data; end
      end else begin
        if (t) m_over = 1;
        k++;
        if (k <= 64) begin
          n = int'((m_snap >> (32 * ((k - 1) / 8) + 4 * (7 - (k - 1) % 8))) & 256'hF);
          e_we = 1; e_busy = 1; e_addr = 6'(k - 1);
          e_data = hexc(n, 1); e_data_l = hexc(n, 0);
        end else begin
          e_done = 1; k = -1;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (m_on) begin
      chk("we", we, e_we);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("overrun", overrun, m_over);
      chk("lc_we", we_l, e_we);
      chk("lc_done", done_l, e_done);
      if (e_we) begin
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, e_data);
        chk("lc_wr_data", wr_data_l, e_data_l);
      end
    end
    if (we) begin mem[wr_addr] = wr_data; mem_lc[wr_addr_l] = wr_data_l; wcount++; end
    if (done) begin dcount++; done_cyc = cyc; end
  end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_req(output int trg);
    refresh_req = 1; tick(); trg = cyc; refresh_req = 0;
  endtask
  task automatic wait_done;
    int d0, i;
    d0 = dcount; i = 0;
    while (dcount == d0 && i < 200) begin tick(); i++; end
    if (dcount == d0) chk("done_timeout", 64'(i), 64'd0);
  endtask
  task automatic wait_writes(int base, int n);
    int i;
    i = 0;
    while (wcount - base < n && i < 200) begin tick(); i++; end
    if (wcount - base < n) chk("write_timeout", 64'(wcount - base), 64'(n));
  endtask
  initial begin
    int w0, d0, trg;
    bit ok, ok_lc;
    tick(3);
    chk("rst_we", we, 0); chk("rst_addr", wr_addr, 0); chk("rst_data", wr_data, 8'h20);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_overrun", overrun, 0);
    rst = 0; tick(2);
    dbg_data[31:0] = 32'h0123ABCD;
    w0 = wcount; pulse_req(trg); wait_done();
    chk("t1_latency", 64'(done_cyc - trg), 65); chk("t1_writes", 64'(wcount - w0), 64);
    for (int i = 0; i < 8; i++) chk("t1_word0", mem[i], exp0[i]);
    ok = 1; for (int i = 8; i < 64; i++) if (mem[i] !== 8'h30) ok = 0;
    chk("t1_zeros", ok, 1);
    w0 = wcount; print_fin = 1; tick(10); print_fin = 0; wait_done(); tick(5);
    chk("pf_level_writes", 64'(wcount - w0), 64); chk("pf_level_overrun", overrun, 0);
    freeze = 1; w0 = wcount; print_fin = 1; tick(); print_fin = 0; tick(80);
    chk("freeze_idle_writes", 64'(wcount - w0), 0); chk("freeze_idle_overrun", overrun, 0);
    freeze = 0;
    w0 = wcount; pulse_req(trg); wait_writes(w0, 30); freeze = 1; wait_done(); freeze = 0;
    chk("freeze_mid_writes", 64'(wcount - w0), 64);
    w0 = wcount; refresh_req = 1; print_fin = 1; tick(); refresh_req = 0; print_fin = 0;
    wait_done(); tick(80);
    chk("same_cycle_writes", 64'(wcount - w0), 64); chk("same_cycle_overrun", overrun, 0);
    w0 = wcount; pulse_req(trg); wait_writes(w0, 20); print_fin = 1; tick(); print_fin = 0;
    wait_done(); tick(80);
    chk("overrun_writes", 64'(wcount - w0), 64); chk("overrun_set", overrun, 1);
    dbg_data = '0; dbg_data[31:0] = 32'h0123ABCD;
    pulse_req(trg); dbg_data = {8{32'hFFFFFFFF}}; wait_done();
    for (int i = 0; i < 8; i++) chk("snap_word0", mem[i], exp0[i]);
    pulse_req(trg); wait_done();
    ok = 1; ok_lc = 1;
    for (int i = 0; i < 64; i++) begin
      if (mem[i] !== 8'h46) ok = 0;
      if (mem_lc[i] !== 8'h66) ok_lc = 0;
    end
    chk("all_F_upper", ok, 1); chk("all_f_lower", ok_lc, 1);
    dbg_data = '0; dbg_data[255:224] = 32'h89ABCDEF;
    pulse_req(trg); wait_done();
    for (int i = 0; i < 8; i++) chk("word7", mem[56 + i], exp7[i]);
    w0 = wcount; d0 = dcount; pulse_req(trg); wait_writes(w0, 40);
    rst = 1; tick();
    chk("rst_mid_we", we, 0); chk("rst_mid_busy", busy, 0); chk("rst_mid_done", done, 0);
    rst = 0; tick(70);
    chk("rst_mid_no_done", 64'(dcount - d0), 0); chk("rst_mid_overrun", overrun, 0);
    w0 = wcount; pulse_req(trg); wait_done();
    chk("restart_latency", 64'(done_cyc - trg), 65); chk("restart_writes", 64'(wcount - w0), 64);
    for (int i = 0; i < 8; i++) chk("restart_word7", mem[56 + i], exp7[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dbg_hex_writer.md
Name: dbg_hex_writer

Overview:
Upstream feeder for the OLED character display. It snapshots a 256-bit debug bus, treated as eight 32-bit pipeline debug words. It renders the snapshot as 64 ASCII hex characters, 8 per word, filling the 4x16 screen, and streams them into the 64-entry character buffer through its write port (we / wr_addr / wr_data). Refreshes are paced by the OLED controller's print_fin frame-complete signal, or by an explicit refresh request.

Parameters:
UPPERCASE, 1, 1 = hex letters A-F (0x41-0x46); 0 = a-f (0x61-0x66)
AUTO_REFRESH, 1, 1 = a print_fin rising edge triggers a refresh; 0 = only refresh_req triggers

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
dbg_data  input  256  debug words; word w = dbg_data[32*w+31:32*w], w = 0..7
print_fin  input  1  frame-complete level/pulse from the OLED controller
refresh_req  input  1  single-cycle manual refresh request
freeze  input  1  while high, no new refresh starts; a write burst in progress completes
we  output  1  character buffer write enable
wr_addr  output  6  character buffer address
wr_data  output  8  ASCII character code
busy  output  1  high while a write burst is in progress
done  output  1  single-cycle pulse after the last write of a burst
overrun  output  1  sticky: a trigger arrived while busy

Behaviour:
- All outputs are registered. Reset values: we=0, wr_addr=0, wr_data=0x20, busy=0, done=0, overrun=0. The internal snapshot register, index counter and print_fin edge register are also cleared.
- Trigger: trig = refresh_req | (AUTO_REFRESH & print_fin & ~print_fin_d), where print_fin_d is print_fin delayed by one cycle.
- States:
  - IDLE: if trig & ~freeze -> load snap <= dbg_data, idx <= 0, go to WRITE. If trig & freeze -> stay in IDLE; the trigger is dropped and overrun is not set.
  - WRITE: each cycle drive we=1, wr_addr=idx, wr_data=hex(nibble(idx)), then idx++. After idx=63 is issued -> go to DONE.
  - DONE: one cycle, done=1, we=0 -> go to IDLE.
- Nibble mapping: word = idx[5:3]; idx[2:0]=0 selects the word's bits [31:28] (MSB first), and idx[2:0]=7 selects bits [3:0].
- Hex mapping: 0-9 -> 0x30-0x39; 10-15 -> 0x41-0x46 or 0x61-0x66 per UPPERCASE.
- Latency: trig sampled high at edge N -> we=1 with addr 0 at edge N+1, addr 63 at edge N+64, done=1 at edge N+65, busy low from edge N+65.
- busy=1 exactly over the 64 write cycles.
- Exactly 64 consecutive writes per burst, with no gaps and no back-pressure.
- dbg_data changes during a burst have no effect; only the snapshot is rendered.
- Trigger while in WRITE or DONE: ignored, and overrun <= 1. overrun is cleared only by rst.
- refresh_req and a print_fin edge in the same cycle count as one trigger.
- freeze rising mid-burst: the burst completes. freeze only gates starting a burst in IDLE.
- rst mid-burst: the next edge gives we=0, busy=0, state IDLE, and no done pulse.
- idx is 6 bits. Its wrap from 63 to 0 is never observed on wr_addr because the state leaves WRITE first.

Test Plan:
- Reset, then dbg_data word0=0x0123ABCD, all others 0, UPPERCASE=1, pulse refresh_req -> addrs 0..7 carry 0x30,0x31,0x32,0x33,0x41,0x42,0x43,0x44; addrs 8..63 carry 0x30; done at trigger+65.
- Hold print_fin high 10 cycles with AUTO_REFRESH=1 -> exactly one burst of 64 writes; assert a second print_fin edge at write 20 -> overrun=1, still only one burst.
- freeze=1, pulse print_fin -> no writes, overrun=0. freeze=1 at write 30 of an active burst -> all 64 writes complete.
- Change dbg_data to 0xFFFFFFFF x8 one cycle after the trigger -> written chars still reflect the old snapshot; the next burst gives 0x46 for all 64 (0x66 with UPPERCASE=0).
- Assert rst at write 40 -> next cycle we=0, busy=0, no done; a following refresh_req restarts at addr 0.
- word7=0x89ABCDEF -> addrs 56..63 carry 0x38,0x39,0x41,0x42,0x43,0x44,0x45,0x46.
